// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs,
// status codes and the writeback FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

    // Undefined status encodings collapse to INS.
    function automatic logic [2:0] norm_stat(input logic [2:0] s);
        case (s)
            S_AOK, S_HLT, S_ADR: norm_stat = s;
            default:             norm_stat = S_INS;
        endcase
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// 15x64 register file, two async read ports, two write ports.
// Port M wins when both ports target the same register.
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);

    logic [63:0] regs [15];
    logic        e_ok;
    logic        m_ok;

    assign m_ok = we_m && (dst_m != RNONE);
    assign e_ok = we_e && (dst_e != RNONE) && !(m_ok && (dst_m == dst_e));

    assign val_a = (src_a == RNONE) ? 64'h0 : regs[src_a];
    assign val_b = (src_b == RNONE) ? 64'h0 : regs[src_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) regs[i] <= 64'h0;
        end else begin
            if (e_ok) regs[dst_e] <= val_e;
            if (m_ok) regs[dst_m] <= val_m;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 decode/writeback: register ID derivation, commit gating,
// RUN/HALTED status FSM and retired-instruction counter.
module writeback_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [2:0]  stat_in,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [2:0]  stat_out,
    output logic        halted,
    output logic [31:0] retired
);

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    wb_state_t   state_q, state_d;
    logic [2:0]  stat_q;
    logic [31:0] retired_q;
    logic        commit;
    logic        fault;

    always_comb begin
        src_a = RNONE;
        unique case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = rA;
            I_POPQ, I_RET:                      src_a = RSP;
            default: ;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        unique case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:           src_b = rB;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:      src_b = RSP;
            default: ;
        endcase
    end

    always_comb begin
        dst_e = RNONE;
        unique case (icode)
            I_RRMOVQ:                         dst_e = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:                  dst_e = rB;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:   dst_e = RSP;
            default: ;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        unique case (icode)
            I_MRMOVQ, I_POPQ: dst_m = rA;
            default: ;
        endcase
    end

    assign commit = valid && (state_q == RUN) && (stat_in == S_AOK);
    assign fault  = valid && (state_q == RUN) && (stat_in != S_AOK);

    y86_regfile u_rf (
        .clk   (clk),
        .rst   (rst),
        .src_a (src_a),
        .src_b (src_b),
        .val_a (valA),
        .val_b (valB),
        .we_e  (commit),
        .dst_e (dst_e),
        .val_e (valE),
        .we_m  (commit),
        .dst_m (dst_m),
        .val_m (valM)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fault) state_d = HALTED;
    end

    always_comb begin
        halted = (state_q == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q    <= S_AOK;
            retired_q <= 32'h0;
        end else begin
            if (fault) stat_q <= norm_stat(stat_in);
            if (commit && (retired_q != 32'hFFFF_FFFF))
                retired_q <= retired_q + 32'd1;
        end
    end

    assign stat_out = stat_q;
    assign retired  = retired_q;

endmodule
